// File: rtl/data_mem_resp_if.sv
// Load/store request and response channels between the core (master) and data memory (slave).
interface data_mem_resp_if #(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_resp.sv
// Data-memory responder: byte-addressed little-endian array behind a valid/ready channel with a programmable wait.
// Define DATA_MEM_ALIGN_CHECK_EN to report misaligned/illegal-size requests on resp_err instead of forcing alignment.
module data_mem_resp #(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LATENCY    = 2
) (
    input  logic           clk,
    input  logic           rst,
    data_mem_resp_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic                  req_ready_q;
    logic                  resp_valid_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;
    logic                  resp_err_q;

    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [1:0]            size_q;
    logic                  unsigned_q;

    logic [7:0] mem [DEPTH];

    logic                  acc_write;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic [1:0]            acc_size;
    logic                  acc_unsigned;
    logic                  acc_err;
    logic [1:0]            eff_size;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] ba [4];
    logic [7:0]            rb [4];
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] resp_data_c;
    logic                  acc_go;
    logic                  wr_en;

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

    // With zero latency the access uses the live request fields, otherwise the captured copy.
    always_comb begin
        acc_write    = write_q;
        acc_addr     = addr_q;
        acc_wdata    = wdata_q;
        acc_size     = size_q;
        acc_unsigned = unsigned_q;
        if (state == IDLE) begin
            acc_write    = bus.req_write;
            acc_addr     = bus.req_addr;
            acc_wdata    = bus.req_wdata;
            acc_size     = bus.req_size;
            acc_unsigned = bus.req_unsigned;
        end
        eff_size = acc_size;
        base     = acc_addr;
        acc_err  = 1'b0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
        case (acc_size)
            2'd0:    acc_err = 1'b0;
            2'd1:    acc_err = acc_addr[0];
            2'd2:    acc_err = |acc_addr[1:0];
            default: acc_err = 1'b1;
        endcase
`else
        case (acc_size)
            2'd1: base[0] = 1'b0;
            2'd2, 2'd3: begin
                eff_size  = 2'd2;
                base[1:0] = 2'b00;
            end
            default: ;
        endcase
`endif
    end

    // Byte lanes, little-endian, address arithmetic wraps at the array size.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            ba[i] = base + ADDR_WIDTH'(i);
            rb[i] = mem[ba[i]];
        end
        case (eff_size)
            2'd0:    load_data = acc_unsigned ? {24'h0, rb[0]} : {{24{rb[0][7]}}, rb[0]};
            2'd1:    load_data = acc_unsigned ? {16'h0, rb[1], rb[0]} : {{16{rb[1][7]}}, rb[1], rb[0]};
            default: load_data = {rb[3], rb[2], rb[1], rb[0]};
        endcase
        resp_data_c = (acc_write || acc_err) ? '0 : load_data;
    end

    assign acc_go = !rst && (((state == IDLE) && bus.req_valid && req_ready_q && (LATENCY == 0))
                             || ((state == WAIT) && (cnt == '0)));
    assign wr_en  = acc_go && acc_write && !acc_err;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ba[0]] <= acc_wdata[7:0];
            if (eff_size != 2'd0) mem[ba[1]] <= acc_wdata[15:8];
            if (eff_size == 2'd2) begin
                mem[ba[2]] <= acc_wdata[23:16];
                mem[ba[3]] <= acc_wdata[31:24];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        write_q     <= bus.req_write;
                        addr_q      <= bus.req_addr;
                        wdata_q     <= bus.req_wdata;
                        size_q      <= bus.req_size;
                        unsigned_q  <= bus.req_unsigned;
                        req_ready_q <= 1'b0;
                        if (LATENCY == 0) begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= resp_data_c;
                            resp_err_q   <= acc_err;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state        <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= resp_data_c;
                        resp_err_q   <= acc_err;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state        <= IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_resp.sv
// Randomized and directed bench for data_mem_resp: a LATENCY=2 and a LATENCY=0 instance checked against a byte-array model.
module tb_data_mem_resp;
    localparam int unsigned AW    = 17;
    localparam int unsigned DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          sel = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic [1:0]    req_size = '0;
    logic          req_unsigned = 1'b0;
    logic          resp_ready = 1'b0;

    data_mem_resp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus2 ();
    data_mem_resp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus0 ();

    assign bus2.req_valid    = req_valid && (sel == 1'b0);
    assign bus2.resp_ready   = resp_ready && (sel == 1'b0);
    assign bus2.req_write    = req_write;
    assign bus2.req_addr     = req_addr;
    assign bus2.req_wdata    = req_wdata;
    assign bus2.req_size     = req_size;
    assign bus2.req_unsigned = req_unsigned;
    assign bus0.req_valid    = req_valid && (sel == 1'b1);
    assign bus0.resp_ready   = resp_ready && (sel == 1'b1);
    assign bus0.req_write    = req_write;
    assign bus0.req_addr     = req_addr;
    assign bus0.req_wdata    = req_wdata;
    assign bus0.req_size     = req_size;
    assign bus0.req_unsigned = req_unsigned;

    data_mem_resp #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .LATENCY(2)) u_lat2 (
        .clk(clk), .rst(rst), .bus(bus2.slave));
    data_mem_resp #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .LATENCY(0)) u_lat0 (
        .clk(clk), .rst(rst), .bus(bus0.slave));

    wire        cur_req_ready  = sel ? bus0.req_ready  : bus2.req_ready;
    wire        cur_resp_valid = sel ? bus0.resp_valid : bus2.resp_valid;
    wire [31:0] cur_rdata      = sel ? bus0.resp_rdata : bus2.resp_rdata;
    wire        cur_err        = sel ? bus0.resp_err   : bus2.resp_err;

    int total = 0;
    int bad   = 0;
    bit [7:0] model_mem [int unsigned];

    function automatic int cur_lat();
        return sel ? 0 : 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s (latency %0d): got %h want %h", tag, cur_lat(), got, exp);
        end
    endtask

    function automatic int unsigned mkey(input int unsigned a);
        return (int'(sel) * DEPTH) + (a % DEPTH);
    endfunction

    // Reference behaviour: aligned/forced-aligned access on a byte array, extension by size.
    function automatic void model_op(input bit w, input int unsigned a, input logic [31:0] wd,
                                     input int sz_in, input bit u,
                                     output bit e, output logic [31:0] rd);
        int          sz = sz_in;
        int unsigned b  = a;
        int          nb;
        logic [31:0] v    = '0;
        logic [31:0] ones = '1;
        e  = 1'b0;
        rd = '0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
        if (sz == 3 || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0)) e = 1'b1;
`else
        if (sz == 3) sz = 2;
        if (sz == 1) b = a - (a % 2);
        if (sz == 2) b = a - (a % 4);
`endif
        nb = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
        if (!e) begin
            if (w) begin
                for (int i = 0; i < nb; i++) model_mem[mkey(b + i)] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < nb; i++) v = v | (32'(model_mem[mkey(b + i)]) << (8 * i));
                if (nb < 4 && !u && v[8*nb-1]) v = v | (ones << (8 * nb));
                rd = v;
            end
        end
    endfunction

    task automatic txn(input bit w, input int unsigned a, input logic [31:0] wd,
                       input logic [1:0] sz, input bit u, input int hold, output logic [31:0] got);
        bit          e_exp;
        logic [31:0] rd_exp;
        logic [31:0] first;
        int          n = 99;
        got = 'x;
        model_op(w, a, wd, int'(sz), u, e_exp, rd_exp);
        @(negedge clk);
        req_write = w; req_addr = AW'(a); req_wdata = wd; req_size = sz; req_unsigned = u;
        req_valid = 1'b1; resp_ready = 1'b0;
        for (int i = 0; i < 20 && !cur_req_ready; i++) @(negedge clk);
        chk("req_ready_before_accept", 32'(cur_req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("req_ready_busy", 32'(cur_req_ready), 32'd0);
        for (int i = 1; i <= 30; i++) begin
            if (cur_resp_valid) begin
                n = i;
                break;
            end
            @(negedge clk);
        end
        chk("resp_latency", 32'(n), 32'(cur_lat() + 1));
        if (n == 99) return;
        got = cur_rdata;
        chk("resp_rdata", cur_rdata, rd_exp);
        chk("resp_err", 32'(cur_err), 32'(e_exp));
        first = cur_rdata;
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", 32'(cur_resp_valid), 32'd1);
            chk("hold_rdata", cur_rdata, first);
            chk("hold_req_ready", 32'(cur_req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("after_hs_valid", 32'(cur_resp_valid), 32'd0);
        chk("after_hs_ready", 32'(cur_req_ready), 32'd1);
    endtask

    task automatic directed();
        logic [31:0] r;
        txn(1'b1, 32'h100, 32'hDEADBEEF, 2'd2, 1'b0, 0, r);
        txn(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 0, r);
        chk("plan_word_load", r, 32'hDEADBEEF);
        txn(1'b0, 32'h103, 32'h0, 2'd0, 1'b0, 0, r);
        chk("plan_byte_signed", r, 32'hFFFFFFDE);
        txn(1'b0, 32'h103, 32'h0, 2'd0, 1'b1, 0, r);
        chk("plan_byte_unsigned", r, 32'h000000DE);
        txn(1'b0, 32'h100, 32'h0, 2'd1, 1'b0, 0, r);
        chk("plan_half_signed", r, 32'hFFFFBEEF);
        txn(1'b1, 32'h102, 32'h00001234, 2'd1, 1'b0, 0, r);
        txn(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 5, r);
        chk("plan_half_store", r, 32'h1234BEEF);
        txn(1'b1, 32'h101, 32'hA5A5C3C3, 2'd2, 1'b0, 0, r);
        txn(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 0, r);
`ifdef DATA_MEM_ALIGN_CHECK_EN
        chk("plan_misaligned_kept", r, 32'h1234BEEF);
`else
        chk("plan_misaligned_forced", r, 32'hA5A5C3C3);
`endif
        txn(1'b0, 32'h100, 32'h0, 2'd3, 1'b1, 1, r);
    endtask

    task automatic random_ops(input int count);
        logic [31:0] r;
        for (int i = 0; i < 8; i++) txn(1'b1, 32'h400 + 4 * i, $urandom, 2'd2, 1'b0, 0, r);
        txn(1'b1, DEPTH - 8, $urandom, 2'd2, 1'b0, 0, r);
        txn(1'b1, DEPTH - 4, $urandom, 2'd2, 1'b0, 0, r);
        for (int i = 0; i < count; i++) begin
            int unsigned a;
            a = ($urandom_range(0, 3) == 0) ? (DEPTH - 8 + $urandom_range(0, 7))
                                            : (32'h400 + $urandom_range(0, 31));
            txn(1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), $urandom_range(0, 2), r);
        end
    endtask

    initial begin
        logic [31:0] r;
        int          rose;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_valid_l2", 32'(bus2.resp_valid), 32'd0);
        chk("rst_rdata_l2", bus2.resp_rdata, 32'd0);
        chk("rst_err_l2", 32'(bus2.resp_err), 32'd0);
        chk("rst_valid_l0", 32'(bus0.resp_valid), 32'd0);
        @(negedge clk);
        chk("rst_ready_l2", 32'(bus2.req_ready), 32'd1);
        chk("rst_ready_l0", 32'(bus0.req_ready), 32'd1);

        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            sel = 1'(s);
            directed();
        end

        // Reset while a store sits in WAIT: it must never commit or respond.
        @(negedge clk);
        sel = 1'b0;
        txn(1'b1, 32'h200, 32'h11223344, 2'd2, 1'b0, 0, r);
        @(negedge clk);
        req_write = 1'b1; req_addr = AW'(32'h200); req_wdata = 32'hCAFEF00D;
        req_size = 2'd2; req_unsigned = 1'b0; req_valid = 1'b1;
        for (int i = 0; i < 20 && !cur_req_ready; i++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rose = 0;
        for (int i = 0; i < 6; i++) begin
            if (cur_resp_valid) rose++;
            if (i == 1) chk("rst_mid_ready", 32'(cur_req_ready), 32'd1);
            @(negedge clk);
        end
        chk("rst_mid_no_resp", 32'(rose), 32'd0);
        txn(1'b0, 32'h200, 32'h0, 2'd2, 1'b0, 0, r);
        chk("rst_mid_old_value", r, 32'h11223344);

        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            sel = 1'(s);
            random_ops(60);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
